// File: rtl/ex_mem_wb_ctrl_if.sv
// ID/EX bundle into the back half of the pipeline, plus the decode
// controls, branch result and writeback returned to the decode stage.
interface ex_mem_wb_ctrl_if;
  logic        in_valid;
  logic [63:0] pc;
  logic [31:0] instr;
  logic [63:0] imm;
  logic [63:0] rdata1;
  logic [63:0] rdata2;
  logic        reg2loc;
  logic        ctl_b;
  logic        ctl_bz;
  logic        ctl_bnz;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic [1:0]  alu_op;
  logic [1:0]  alu_src;
  logic [63:0] branch_addr;
  logic        pc_src;
  logic [63:0] wb_data;
  logic [4:0]  wb_reg;
  logic        wb_en;

  modport master (
    output in_valid, pc, instr, imm, rdata1, rdata2,
    input  reg2loc, ctl_b, ctl_bz, ctl_bnz, mem_read, mem_write,
           mem_to_reg, reg_write, alu_op, alu_src,
           branch_addr, pc_src, wb_data, wb_reg, wb_en
  );

  modport slave (
    input  in_valid, pc, instr, imm, rdata1, rdata2,
    output reg2loc, ctl_b, ctl_bz, ctl_bnz, mem_read, mem_write,
           mem_to_reg, reg_write, alu_op, alu_src,
           branch_addr, pc_src, wb_data, wb_reg, wb_en
  );
endinterface

// File: rtl/ex_mem_wb_ctrl.sv
// LEGv8-subset back half: opcode decode, EX stage with branch resolution,
// and MEM/WB stage with an internal 64-bit data memory.
module ex_mem_wb_ctrl #(
  parameter int unsigned DMEM_WORDS = 32
) (
  input logic                 clk,
  input logic                 rst,
  ex_mem_wb_ctrl_if.slave     bus
);
  localparam int unsigned AW = $clog2(DMEM_WORDS);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic [10:0] op;
  logic [63:0] alu_b;
  logic [63:0] alu_res;
  logic        take;

  assign op = bus.instr[31:21];

  always_comb begin
    bus.reg2loc    = 1'b0;
    bus.ctl_b      = 1'b0;
    bus.ctl_bz     = 1'b0;
    bus.ctl_bnz    = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.alu_op     = 2'b00;
    bus.alu_src    = 2'b00;
    casez (op)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        bus.reg_write = 1'b1;
        bus.alu_op    = 2'b10;
      end
      11'b1001000100?, 11'b1101000100?: begin
        bus.reg_write = 1'b1;
        bus.alu_op    = 2'b11;
        bus.alu_src   = 2'b01;
      end
      OP_LDUR: begin
        bus.mem_read   = 1'b1;
        bus.mem_to_reg = 1'b1;
        bus.reg_write  = 1'b1;
        bus.alu_src    = 2'b01;
      end
      OP_STUR: begin
        bus.mem_write = 1'b1;
        bus.reg2loc   = 1'b1;
        bus.alu_src   = 2'b01;
      end
      11'b000101?????: bus.ctl_b = 1'b1;
      11'b10110100???: begin
        bus.ctl_bz  = 1'b1;
        bus.reg2loc = 1'b1;
        bus.alu_op  = 2'b01;
      end
      11'b10110101???: begin
        bus.ctl_bnz = 1'b1;
        bus.reg2loc = 1'b1;
        bus.alu_op  = 2'b01;
      end
      default: ;
    endcase
  end

  assign alu_b = (bus.alu_src == 2'b01) ? bus.imm : bus.rdata2;

  always_comb begin
    alu_res = bus.rdata1 + alu_b;
    case (bus.alu_op)
      2'b01: alu_res = alu_b;
      2'b10: begin
        case (op)
          OP_SUB:  alu_res = bus.rdata1 - alu_b;
          OP_AND:  alu_res = bus.rdata1 & alu_b;
          OP_ORR:  alu_res = bus.rdata1 | alu_b;
          default: alu_res = bus.rdata1 + alu_b;
        endcase
      end
      2'b11: alu_res = bus.instr[30] ? bus.rdata1 - alu_b : bus.rdata1 + alu_b;
      default: ;
    endcase
  end

  assign take = bus.in_valid & (bus.ctl_b
              | (bus.ctl_bz  & (bus.rdata2 == '0))
              | (bus.ctl_bnz & (bus.rdata2 != '0)));

  // EX stage registers; controls are gated by in_valid so bubbles are inert
  logic [63:0] ex_alu;
  logic [63:0] ex_rdata2;
  logic [4:0]  ex_rd;
  logic        ex_mem_write;
  logic        ex_mem_to_reg;
  logic        ex_reg_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_alu          <= '0;
      ex_rdata2       <= '0;
      ex_rd           <= '0;
      ex_mem_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_reg_write    <= 1'b0;
      bus.branch_addr <= '0;
      bus.pc_src      <= 1'b0;
    end else begin
      ex_alu          <= alu_res;
      ex_rdata2       <= bus.rdata2;
      ex_rd           <= bus.instr[4:0];
      ex_mem_write    <= bus.in_valid & bus.mem_write;
      ex_mem_to_reg   <= bus.in_valid & bus.mem_to_reg;
      ex_reg_write    <= bus.in_valid & bus.reg_write;
      bus.branch_addr <= bus.pc + (bus.imm << 2);
      bus.pc_src      <= take;
    end
  end

  logic [63:0]   dmem [DMEM_WORDS];
  logic [AW-1:0] idx;

  assign idx = ex_alu[AW+2:3];

  // The load reads the pre-edge memory contents, so a store landing on the
  // same edge is never observed by it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
      bus.wb_data <= '0;
      bus.wb_reg  <= '0;
      bus.wb_en   <= 1'b0;
    end else begin
      if (ex_mem_write) dmem[idx] <= ex_rdata2;
      bus.wb_data <= ex_mem_to_reg ? dmem[idx] : ex_alu;
      bus.wb_reg  <= ex_rd;
      bus.wb_en   <= ex_reg_write & (ex_rd != 5'd31);
    end
  end
endmodule

// File: tb/tb_ex_mem_wb_ctrl.sv
// Directed bench for ex_mem_wb_ctrl: decode table, ALU writeback, memory,
// branches, bubbles and asynchronous reset.
module tb_ex_mem_wb_ctrl;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ex_mem_wb_ctrl_if bus ();

  ex_mem_wb_ctrl #(.DMEM_WORDS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] B    = 11'b00010100000;
  localparam logic [10:0] CBZ  = 11'b10110100000;
  localparam logic [10:0] CBNZ = 11'b10110101000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [10:0] op, input logic [4:0] rd,
                       input logic [63:0] pc, input logic [63:0] imm,
                       input logic [63:0] r1, input logic [63:0] r2);
    bus.in_valid = v;
    bus.instr    = {op, 16'h0000, rd};
    bus.pc       = pc;
    bus.imm      = imm;
    bus.rdata1   = r1;
    bus.rdata2   = r2;
  endtask

  task automatic bubble();
    drive(1'b0, 11'h7FF, 5'd0, '0, '0, '0, '0);
  endtask

  task automatic test_reset();
    logic [135:0] got;
    #2 rst = 1'b1;
    #3;
    got = {bus.branch_addr, bus.pc_src, bus.wb_data, bus.wb_reg, bus.wb_en};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h required 0", got);
    end
    step();
    #2 rst = 1'b0;
  endtask

  task automatic test_decode();
    logic [10:0] ops [13];
    logic [11:0] exp [13];
    logic [11:0] got;
    ops = '{ADD, SUB, 11'b10001010000, 11'b10101010000,
            11'b10010001000, 11'b10010001001, 11'b11010001000,
            LDUR, STUR, 11'b00010110101, 11'b10110100111, 11'b10110101010,
            11'b11111111111};
    exp = '{12'b000000011000, 12'b000000011000, 12'b000000011000, 12'b000000011000,
            12'b000000011101, 12'b000000011101, 12'b000000011101,
            12'b000010110001, 12'b100001000001, 12'b010000000000,
            12'b101000000100, 12'b100100000100, 12'b000000000000};
    for (int i = 0; i < 13; i++) begin
      bus.instr = {ops[i], 21'h0};
      #1;
      got = {bus.reg2loc, bus.ctl_b, bus.ctl_bz, bus.ctl_bnz, bus.mem_read,
             bus.mem_write, bus.mem_to_reg, bus.reg_write, bus.alu_op, bus.alu_src};
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL decode_%b: got %b required %b", ops[i], got, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, ADD, 5'd3, '0, '0, 64'd5, 64'd7);
    step();
    drive(1'b1, SUB, 5'd4, '0, '0, 64'd5, 64'd7);
    step();
    checks++;
    if ({bus.wb_data, bus.wb_reg, bus.wb_en} !== {64'd12, 5'd3, 1'b1}) begin
      errors++;
      $display("FAIL add_wb: got %h/%0d/%b required 12/3/1", bus.wb_data, bus.wb_reg, bus.wb_en);
    end
    bubble();
    step();
    checks++;
    if ({bus.wb_data, bus.wb_reg, bus.wb_en} !== {64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 1'b1}) begin
      errors++;
      $display("FAIL sub_wb: got %h/%0d/%b required fffffffffffffffe/4/1", bus.wb_data, bus.wb_reg, bus.wb_en);
    end
    step();
    checks++;
    if (bus.wb_en !== 1'b0) begin
      errors++;
      $display("FAIL bubble_wb_en: got %b required 0", bus.wb_en);
    end
  endtask

  task automatic test_mem();
    drive(1'b1, STUR, 5'd5, '0, 64'd8, 64'd16, 64'hDEADBEEF);
    step();
    drive(1'b1, LDUR, 5'd9, '0, 64'd0, 64'd24, '0);
    step();
    checks++;
    if (bus.wb_en !== 1'b0) begin
      errors++;
      $display("FAIL stur_wb_en: got %b required 0", bus.wb_en);
    end
    // 280 = 35 words wraps to index 3; 27 has byte offset 3 within word 3
    drive(1'b1, LDUR, 5'd10, '0, 64'd256, 64'd24, '0);
    step();
    checks++;
    if ({bus.wb_data, bus.wb_reg, bus.wb_en} !== {64'hDEADBEEF, 5'd9, 1'b1}) begin
      errors++;
      $display("FAIL ldur_wb: got %h/%0d/%b required deadbeef/9/1", bus.wb_data, bus.wb_reg, bus.wb_en);
    end
    drive(1'b1, LDUR, 5'd11, '0, 64'd0, 64'd27, '0);
    step();
    checks++;
    if (bus.wb_data !== 64'hDEADBEEF) begin
      errors++;
      $display("FAIL ldur_wrap: got %h required deadbeef", bus.wb_data);
    end
    bubble();
    step();
    checks++;
    if (bus.wb_data !== 64'hDEADBEEF) begin
      errors++;
      $display("FAIL ldur_byteoff: got %h required deadbeef", bus.wb_data);
    end
  endtask

  task automatic test_branch();
    logic [10:0] ops  [6];
    logic [63:0] r2s  [6];
    logic        exps [6];
    ops  = '{B, CBZ, CBZ, CBNZ, CBNZ, B};
    r2s  = '{64'd9, 64'd0, 64'd1, 64'd0, 64'd1, 64'd0};
    exps = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ops[i], 5'd0, 64'h100, 64'd4, '0, r2s[i]);
      step();
      checks++;
      if (bus.pc_src !== exps[i] || bus.branch_addr !== 64'h110) begin
        errors++;
        $display("FAIL branch_%0d: got %b/%h required %b/110", i, bus.pc_src, bus.branch_addr, exps[i]);
      end
    end
    bubble();
    step();
    checks++;
    if (bus.pc_src !== 1'b0) begin
      errors++;
      $display("FAIL pc_src_pulse: got %b required 0", bus.pc_src);
    end
    drive(1'b1, B, 5'd0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF, '0, '0);
    step();
    checks++;
    if (bus.pc_src !== 1'b1 || bus.branch_addr !== 64'hFC) begin
      errors++;
      $display("FAIL branch_neg: got %b/%h required 1/fc", bus.pc_src, bus.branch_addr);
    end
  endtask

  task automatic test_bubble_xzr();
    drive(1'b0, STUR, 5'd5, '0, 64'd0, 64'd24, 64'h1234);
    step();
    drive(1'b0, B, 5'd0, 64'h100, 64'd4, '0, '0);
    step();
    checks++;
    if (bus.pc_src !== 1'b0) begin
      errors++;
      $display("FAIL bubble_branch: got %b required 0", bus.pc_src);
    end
    drive(1'b1, LDUR, 5'd6, '0, 64'd0, 64'd24, '0);
    step();
    drive(1'b1, ADD, 5'd31, '0, '0, 64'd1, 64'd2);
    step();
    checks++;
    if (bus.wb_data !== 64'hDEADBEEF) begin
      errors++;
      $display("FAIL bubble_store: got %h required deadbeef", bus.wb_data);
    end
    bubble();
    step();
    checks++;
    if (bus.wb_en !== 1'b0 || bus.wb_data !== 64'd3) begin
      errors++;
      $display("FAIL xzr_wb: got %b/%h required 0/3", bus.wb_en, bus.wb_data);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, ADD, 5'd4, 64'h40, 64'd1, 64'd2, 64'd3);
    step();
    bubble();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.branch_addr, bus.pc_src, bus.wb_data, bus.wb_reg, bus.wb_en} !== '0) begin
      errors++;
      $display("FAIL reset_midflight: got %h/%b/%h/%0d/%b required all 0",
               bus.branch_addr, bus.pc_src, bus.wb_data, bus.wb_reg, bus.wb_en);
    end
    step();
    #2 rst = 1'b0;
    step();
    checks++;
    if (bus.wb_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_wb: got %b required 0", bus.wb_en);
    end
    drive(1'b1, LDUR, 5'd7, '0, 64'd0, 64'd24, '0);
    step();
    bubble();
    step();
    checks++;
    if ({bus.wb_data, bus.wb_en} !== {64'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mem: got %h/%b required 0/1", bus.wb_data, bus.wb_en);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    bubble();
    test_reset();
    test_decode();
    test_back_to_back();
    test_mem();
    test_branch();
    test_bubble_xzr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
